capture_ctrl: RTL and testbench

Capture/trigger controller that sits directly downstream of the per-channel trigger blocks and the protocol trigger.
- Combines all channel triggers and the protocol trigger into one trigger condition.
- Generates write enable and address for the circular sample RAM, and asserts armed once enough pre-trigger samples are stored.
- Captures trig_pos post-trigger samples, then flags capture_done to the host command interface.
- Its armed output drives the asynchronous clear of the channel trigger edge flops.

---
 rtl/capture_ctrl.sv | 131 +++++++++++++
 tb/tb_capture_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/capture_ctrl.sv
// capture_ctrl: trigger combine, circular sample-RAM write control and capture sequencing.
// Build option: define TRIG_FILTER_EN to require trig_cond on two consecutive armed cycles.
module capture_ctrl #(
    parameter int NUM_CH = 5,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              wrt_smpl,
    input  logic [NUM_CH-1:0] ch_trig,
    input  logic              prot_trig,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic              clr_done,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic              armed,
    output logic              triggered,
    output logic              capture_done,
    output logic [ADDR_W-1:0] trig_addr
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_W = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] tpos;
    logic [ADDR_W-1:0] post_cnt;
    logic [ADDR_W:0]   pre_cnt;
    logic [ADDR_W:0]   pre_needed;
    logic [ADDR_W:0]   pre_nxt;
    logic [ADDR_W-1:0] waddr_inc;
    logic              in_cap;
    logic              trig_cond;
    logic              done_cond;
    logic              accept;
`ifdef TRIG_FILTER_EN
    logic              trig_q;
`endif

    assign in_cap     = (state == CAPTURE);
    assign trig_cond  = (&ch_trig) & prot_trig;
    assign done_cond  = in_cap & triggered & (post_cnt == tpos);
    assign we         = in_cap & wrt_smpl & ~done_cond;
    assign pre_needed = DEPTH_W - {1'b0, tpos};
    assign pre_nxt    = pre_cnt + ONE_W;
    assign waddr_inc  = we ? (waddr + ONE_A) : waddr;

`ifdef TRIG_FILTER_EN
    assign accept = in_cap & armed & ~triggered & trig_cond & trig_q;
`else
    assign accept = in_cap & armed & ~triggered & trig_cond;
`endif

    // Capture sequencer: arming, trigger acceptance, post-trigger count and done handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            tpos         <= '0;
            pre_cnt      <= '0;
            post_cnt     <= '0;
            waddr        <= '0;
            armed        <= 1'b0;
            triggered    <= 1'b0;
            capture_done <= 1'b0;
            trig_addr    <= '0;
`ifdef TRIG_FILTER_EN
            trig_q       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        tpos      <= trig_pos;
                        waddr     <= '0;
                        pre_cnt   <= '0;
                        post_cnt  <= '0;
                        armed     <= 1'b0;
                        triggered <= 1'b0;
`ifdef TRIG_FILTER_EN
                        trig_q    <= 1'b0;
`endif
                        state     <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (done_cond) begin
                        state        <= DONE;
                        capture_done <= 1'b1;
                        armed        <= 1'b0;
                    end else begin
                        waddr <= waddr_inc;
                        if (we && !armed) begin
                            pre_cnt <= pre_nxt;
                            if (pre_nxt == pre_needed) begin
                                armed <= 1'b1;
                            end
                        end
                        if (we && triggered) begin
                            post_cnt <= post_cnt + ONE_A;
                        end
`ifdef TRIG_FILTER_EN
                        trig_q <= trig_cond & armed;
`endif
                        if (accept) begin
                            triggered <= 1'b1;
                            trig_addr <= waddr_inc;
                        end
                    end
                end
                DONE: begin
                    if (clr_done) begin
                        capture_done <= 1'b0;
                        triggered    <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: table-driven capture runs with a scoreboard of expected results.
// Build option: TRIG_FILTER_EN selects the filtered-trigger expectation columns.
module tb_capture_ctrl;

    localparam int NUM_CH = 5;
    localparam int ADDR_W = 9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              wrt_smpl = 1'b0;
    logic [NUM_CH-1:0] ch_trig = '0;
    logic              prot_trig = 1'b0;
    logic [ADDR_W-1:0] trig_pos = '0;
    logic              clr_done = 1'b0;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic              armed;
    logic              triggered;
    logic              capture_done;
    logic [ADDR_W-1:0] trig_addr;

    capture_ctrl #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .wrt_smpl(wrt_smpl),
        .ch_trig(ch_trig),
        .prot_trig(prot_trig),
        .trig_pos(trig_pos),
        .clr_done(clr_done),
        .we(we),
        .waddr(waddr),
        .armed(armed),
        .triggered(triggered),
        .capture_done(capture_done),
        .trig_addr(trig_addr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int writes = 0;

    // tstart: trig_cond held from this cycle on; pulse: trig only at cycles 20,25,26
    // every: 1 = write each cycle, 2 = write on odd cycles
    // arm: cycle armed first seen; ta/wa/wr: trig_addr, final waddr, writes (f* = filtered)
    typedef struct {
        int tpos;
        int tstart;
        bit pulse;
        int every;
        int arm;
        int ta;
        int wa;
        int wr;
        int fta;
        int fwa;
        int fwr;
    } vec_t;

    typedef struct {
        int arm;
        int ta;
        int wa;
        int wr;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        #1;
        if (we) writes++;
        @(posedge clk);
        #1;
    endtask

    function automatic bit trig_at(input vec_t v, input int c);
        if (v.pulse) return (c == 20) || (c == 25) || (c == 26);
        return c >= v.tstart;
    endfunction

    task automatic drive_trig(input bit t, input int c);
        int k;
        k = c % 6;
        ch_trig = '1;
        prot_trig = 1'b1;
        if (!t) begin
            if (k < NUM_CH) ch_trig[k] = 1'b0;
            else prot_trig = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t g;
        int c;
        int arm_c;
        logic [ADDR_W-1:0] w;
        logic [ADDR_W-1:0] ta;
        trig_pos = ADDR_W'(v.tpos);
        start = 1'b1;
        tick();
        start = 1'b0;
        trig_pos = ADDR_W'($urandom);
        e.arm = v.arm;
`ifdef TRIG_FILTER_EN
        e.ta = v.fta;
        e.wa = v.fwa;
        e.wr = v.fwr;
`else
        e.ta = v.ta;
        e.wa = v.wa;
        e.wr = v.wr;
`endif
        sb.push_back(e);
        writes = 0;
        c = 0;
        arm_c = 0;
        while (!capture_done && c < 1500) begin
            c++;
            wrt_smpl = (v.every == 1) || (c % 2 == 1);
            drive_trig(trig_at(v, c), c);
            tick();
            if (armed && arm_c == 0) arm_c = c;
        end
        wrt_smpl = 1'b0;
        drive_trig(1'b0, 0);
        if (!capture_done) begin
            total++;
            bad++;
            $display("FAIL timeout tpos=%0d: capture_done=0 want 1", v.tpos);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        g = sb.pop_front();
        chk($sformatf("arm_cycle tpos=%0d", v.tpos), arm_c, g.arm);
        chk($sformatf("trig_addr tpos=%0d", v.tpos), int'(trig_addr), g.ta);
        chk($sformatf("final_waddr tpos=%0d", v.tpos), int'(waddr), g.wa);
        chk($sformatf("writes tpos=%0d", v.tpos), writes, g.wr);
        chk($sformatf("armed_cleared tpos=%0d", v.tpos), int'(armed), 0);
        w = waddr;
        ta = trig_addr;
        writes = 0;
        start = 1'b1;
        wrt_smpl = 1'b1;
        tick();
        start = 1'b0;
        chk("done_start_ignored", int'({capture_done, triggered}), 3);
        chk("done_waddr_hold", int'(waddr), int'(w));
        chk("done_no_write", writes, 0);
        clr_done = 1'b1;
        tick();
        clr_done = 1'b0;
        wrt_smpl = 1'b0;
        chk("clr_flags", int'({capture_done, triggered}), 0);
        chk("clr_waddr_kept", int'(waddr), int'(w));
        chk("clr_trig_addr_kept", int'(trig_addr), int'(ta));
    endtask

    initial begin
        vecs[0] = '{256,   0, 0, 1, 256, 257,  1, 513, 258,  2, 514};
        vecs[1] = '{  0,   0, 0, 1, 512,   1,  1, 513,   2,  2, 514};
        vecs[2] = '{500,   0, 0, 1,  12,  13,  1, 513,  14,  2, 514};
        vecs[3] = '{500,  20, 0, 1,  12,  20,  8, 520,  21,  9, 521};
        vecs[4] = '{511,   0, 0, 1,   1,   2,  1, 513,   3,  2, 514};
        vecs[5] = '{100, 450, 0, 1, 412, 450, 38, 550, 451, 39, 551};
        vecs[6] = '{  1,   0, 0, 1, 511,   0,  1, 513,   1,  2, 514};
        vecs[7] = '{500,   0, 0, 2,  23,  12,  0, 512,  13,  1, 513};
        vecs[8] = '{500,   0, 1, 1,  12,  20,  8, 520,  26, 14, 526};

        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tick();
        chk("reset_outputs",
            int'({we, armed, triggered, capture_done, waddr, trig_addr}), 0);
        rst_n = 1'b1;
        clr_done = 1'b1;
        tick();
        clr_done = 1'b0;
        chk("idle_clr_ignored", int'({capture_done, triggered, armed}), 0);

        run_vec(vecs[0]);

        trig_pos = ADDR_W'(500);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            wrt_smpl = 1'b1;
            drive_trig(1'b1, c);
            tick();
        end
        chk("mid_triggered", int'(triggered), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wrt_smpl = 1'b0;
        chk("mid_reset_outputs",
            int'({we, armed, triggered, capture_done, waddr, trig_addr}), 0);

        for (int i = 1; i < 9; i++) run_vec(vecs[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
